// File: rtl/bepu_io.sv
// Back-end peripheral unit: terminates the FEPU_BEPU bus and owns the LED,
// seven-segment, switch and timer registers, returning registered read data.
module bepu_io #(
  parameter int SCAN_BITS = 17,
  parameter int LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      FEPU_BEPU_select,
  input  logic             FEPU_BEPU_w,
  input  logic [31:0]      FEPU_BEPU_data,
  input  logic [31:0]      FEPU_BEPU_addr,
  output logic [31:0]      BEPU_FEPU_data,
  output logic             BEPU_FEPU_valid,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] led,
  output logic [7:0]       an,
  output logic [7:0]       seg
);

  logic [3:0]           sel;
  logic                 access;
  logic                 wr_led;
  logic                 wr_seg;
  logic                 wr_timer;
  logic                 rd;
  logic [31:0]          rd_next;
  logic [LED_W-1:0]     led_reg;
  logic [31:0]          seg_data_reg;
  logic [31:0]          timer_reg;
  logic [SCAN_BITS-1:0] scan_reg;
  logic [7:0]           an_reg;
  logic [7:0]           seg_reg;
  logic [31:0]          rd_data_reg;
  logic                 rd_valid_reg;
  logic [LED_W-1:0]     sw_meta_reg;
  logic [LED_W-1:0]     sw_sync_reg;
  logic [2:0]           digit;
  logic [3:0]           nib [8];
  logic [7:0]           an_next;
  logic [7:0]           seg_next;
  logic                 unused_bits;

  // Address and the non-peripheral select bits carry no meaning here.
  assign unused_bits = ^{FEPU_BEPU_addr, FEPU_BEPU_select[31:5], FEPU_BEPU_select[0]};

  assign sel      = FEPU_BEPU_select[4:1];
  assign access   = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign wr_led   = access && FEPU_BEPU_w && sel[0];
  assign wr_seg   = access && FEPU_BEPU_w && sel[1];
  assign wr_timer = access && FEPU_BEPU_w && sel[3];
  assign rd       = access && !FEPU_BEPU_w;

  always_comb begin
    rd_next = timer_reg;
    if (sel[0])      rd_next = 32'(led_reg);
    else if (sel[1]) rd_next = seg_data_reg;
    else if (sel[2]) rd_next = 32'(sw_sync_reg);
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib[gi] = seg_data_reg[4*gi +: 4];
  end

  assign digit = scan_reg[SCAN_BITS-1 -: 3];

  always_comb begin
    an_next  = ~(8'd1 << digit);
    seg_next = {1'b1, hex7(nib[digit])};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_reg      <= '0;
      seg_data_reg <= '0;
      timer_reg    <= '0;
      scan_reg     <= '0;
      an_reg       <= 8'hFF;
      seg_reg      <= 8'hFF;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
    end else begin
      sw_meta_reg  <= sw;
      sw_sync_reg  <= sw_meta_reg;
      scan_reg     <= scan_reg + 1'b1;
      an_reg       <= an_next;
      seg_reg      <= seg_next;
      rd_valid_reg <= rd;
      if (rd)     rd_data_reg  <= rd_next;
      if (wr_led) led_reg      <= FEPU_BEPU_data[LED_W-1:0];
      if (wr_seg) seg_data_reg <= FEPU_BEPU_data;
      // A load wins over the free-running increment.
      if (wr_timer) timer_reg <= FEPU_BEPU_data;
      else          timer_reg <= timer_reg + 32'd1;
    end
  end

  assign led             = led_reg;
  assign an              = an_reg;
  assign seg             = seg_reg;
  assign BEPU_FEPU_data  = rd_data_reg;
  assign BEPU_FEPU_valid = rd_valid_reg;

endmodule

// File: tb/tb_bepu_io.sv
// Self-checking bench for bepu_io: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_bepu_io;
  localparam int SB = 4;

  logic        clk;
  logic        rst = 1'b0;
  logic [31:0] sel_i = '0;
  logic        w_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] addr_i = '0;
  logic [15:0] sw = '0;
  logic [31:0] rdata;
  logic        valid;
  logic [15:0] led;
  logic [7:0]  an;
  logic [7:0]  seg;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  bepu_io #(.SCAN_BITS(SB), .LED_W(16)) dut (
    .clk(clk), .rst(rst),
    .FEPU_BEPU_select(sel_i), .FEPU_BEPU_w(w_i),
    .FEPU_BEPU_data(data_i), .FEPU_BEPU_addr(addr_i),
    .BEPU_FEPU_data(rdata), .BEPU_FEPU_valid(valid),
    .sw(sw), .led(led), .an(an), .seg(seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: timer as base + elapsed edges, scan from edge count.
  logic [6:0]  hex_tab [16];
  logic [31:0] m_ticks, m_tbase, m_tat;
  logic [15:0] m_led, m_sw1, m_sw2;
  logic [31:0] m_segreg, m_rdata;
  logic        m_valid;
  logic [7:0]  m_an, m_segout;
  wire         m_acc = ($countones(sel_i[4:1]) == 1);
  wire  [31:0] m_timer_now = m_tbase + (m_ticks - m_tat);
  wire  [2:0]  m_digit = 3'((m_ticks % (32'd1 << SB)) / (32'd1 << (SB - 3)));

  initial begin
    hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
    hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
    hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
    hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ticks <= '0; m_tbase <= '0; m_tat <= '0;
      m_led <= '0; m_sw1 <= '0; m_sw2 <= '0;
      m_segreg <= '0; m_rdata <= '0; m_valid <= 1'b0;
      m_an <= 8'hFF; m_segout <= 8'hFF;
    end else begin
      m_ticks  <= m_ticks + 32'd1;
      m_sw1    <= sw;
      m_sw2    <= m_sw1;
      m_an     <= ~(8'd1 << m_digit);
      m_segout <= {1'b1, hex_tab[m_segreg[m_digit*4 +: 4]]};
      m_valid  <= m_acc && !w_i;
      if (m_acc && w_i) begin
        if (sel_i[1]) m_led <= data_i[15:0];
        if (sel_i[2]) m_segreg <= data_i;
        if (sel_i[4]) begin
          m_tbase <= data_i;
          m_tat   <= m_ticks + 32'd1;
        end
      end
      if (m_acc && !w_i)
        m_rdata <= sel_i[1] ? {16'h0, m_led} :
                   sel_i[2] ? m_segreg :
                   sel_i[3] ? {16'h0, m_sw2} : m_timer_now;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_led", 32'(led), 32'(m_led));
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg), 32'(m_segout));
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_data", rdata, m_rdata);
    end
  end

  // Apply one bus cycle just after a falling edge; return at the next one.
  task automatic drive(input logic [31:0] s, input logic w, input logic [31:0] d);
    sel_i = s; w_i = w; data_i = d; addr_i = $urandom;
    if (s[4:1] != 4'd0)
      $display("txn sel=%08h w=%0d data=%08h sw=%04h", s, w, d, sw);
    @(negedge clk);
  endtask

  logic [7:0]  seg_lit [8];
  logic [31:0] picks [7];

  initial begin
    int zeros;
    int d;
    seg_lit[0] = 8'hC0; seg_lit[1] = 8'hF9; seg_lit[2] = 8'hA4; seg_lit[3] = 8'hB0;
    seg_lit[4] = 8'h99; seg_lit[5] = 8'h92; seg_lit[6] = 8'h82; seg_lit[7] = 8'hF8;
    picks[0] = 32'h0; picks[1] = 32'h2; picks[2] = 32'h4; picks[3] = 32'h8;
    picks[4] = 32'h10; picks[5] = 32'h6; picks[6] = 32'h18;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data", rdata, 32'h0);
    chk_en = 1'b1;
    drive(32'h0, 1'b0, 32'h0);
    check("first_an", 32'(an), 32'hFE);
    check("first_seg", 32'(seg), 32'hC0);

    // LED write then read
    drive(32'h2, 1'b1, 32'h0000A5C3);
    check("led_write", 32'(led), 32'hA5C3);
    drive(32'h2, 1'b0, 32'h0);
    check("led_read_data", rdata, 32'h0000A5C3);
    check("led_read_valid", 32'(valid), 32'h1);
    drive(32'h0, 1'b0, 32'h0);
    check("led_valid_drop", 32'(valid), 32'h0);
    check("led_data_hold", rdata, 32'h0000A5C3);

    // Segment scan across all eight digits
    drive(32'h4, 1'b1, 32'h76543210);
    drive(32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 16; c++) begin
      zeros = 0; d = 0;
      for (int i = 0; i < 8; i++)
        if (!an[i]) begin zeros++; d = i; end
      check("scan_an_onehot", 32'(zeros), 32'd1);
      check("scan_seg", 32'(seg), 32'(seg_lit[d]));
      drive(32'h0, 1'b0, 32'h0);
    end

    // Timer load, read-after-load and wrap
    drive(32'h10, 1'b1, 32'hFFFFFFFE);
    drive(32'h10, 1'b0, 32'h0);
    check("timer_load_read", rdata, 32'hFFFFFFFE);
    drive(32'h0, 1'b0, 32'h0);
    drive(32'h10, 1'b0, 32'h0);
    check("timer_wrap_read", rdata, 32'h00000000);
    // Back-to-back reads: consecutive timer values, valid held high
    drive(32'h10, 1'b0, 32'h0);
    check("timer_b2b_read", rdata, 32'h00000001);
    check("timer_b2b_valid", 32'(valid), 32'h1);

    // Switch synchronizer and illegal selects
    sw = 16'h8001;
    repeat (3) drive(32'h0, 1'b0, 32'h0);
    drive(32'h8, 1'b0, 32'h0);
    check("sw_read", rdata, 32'h00008001);
    drive(32'h6, 1'b1, 32'hFFFFFFFF);
    check("illegal_led", 32'(led), 32'hA5C3);
    drive(32'h6, 1'b0, 32'h0);
    check("illegal_valid", 32'(valid), 32'h0);
    drive(32'h4, 1'b0, 32'h0);
    check("illegal_segreg", rdata, 32'h76543210);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 300; n++) begin
      logic [31:0] s;
      logic [31:0] dv;
      s = picks[$urandom_range(0, 6)] | ($urandom & 32'hFFFFFFE1);
      dv = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      drive(s, 1'($urandom), dv);
    end

    // Asynchronous reset in the middle of a write burst
    drive(32'h2, 1'b1, 32'h00001111);
    sel_i = 32'h2; w_i = 1'b1; data_i = 32'h00001234;
    #2 rst = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_an", 32'(an), 32'hFF);
    check("async_seg", 32'(seg), 32'hFF);
    check("async_valid", 32'(valid), 32'h0);
    check("async_data", rdata, 32'h0);
    @(negedge clk);
    sel_i = 32'h0; w_i = 1'b0;
    rst = 1'b1;
    drive(32'h0, 1'b0, 32'h0);
    check("async_led_lost", 32'(led), 32'h0);
    check("async_seg_restart", 32'(seg), 32'hC0);
    repeat (4) drive(32'h0, 1'b0, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
